// File: rtl/y86_execute.sv
// y86_execute: execute stage of the sequential Y86-64 processor.
// Computes the ALU result valE and holds the ZF/SF/OF condition codes.
// It also evaluates the branch / conditional-move condition cnd.
// Optional feature macro: Y86_EXEC_IADDQ_EN. When defined, icode C (iaddq)
// computes valB+valC and updates the condition codes. When undefined,
// icode C is handled as an unknown instruction.
module y86_execute #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic [DATA_W-1:0] valC,
    output logic [DATA_W-1:0] valE,
    output logic              ZF,
    output logic              SF,
    output logic              OF,
    output logic              cnd
);

    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_RRMOVQ = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;
    localparam logic [3:0] IC_IADDQ  = 4'hC;

    localparam int MSB = DATA_W - 1;

    // Architectural condition-code register
    logic r_zf;
    logic r_sf;
    logic r_of;

    logic [DATA_W-1:0] w_valE;
    logic              w_cc_en;
    logic              w_of_next;
    logic              w_cnd;
    logic              w_lt;

    // ALU result selection by instruction class
    always_comb begin
        w_valE = '0;
        case (icode)
            IC_HALT, IC_NOP:    w_valE = '0;
            IC_RRMOVQ:          w_valE = valA;
            IC_IRMOVQ:          w_valE = valC;
            IC_RMMOVQ,
            IC_MRMOVQ:          w_valE = valB + valC;
            IC_OPQ: begin
                case (ifun)
                    4'h0:    w_valE = valB + valA;
                    4'h1:    w_valE = valB - valA;
                    4'h2:    w_valE = valB & valA;
                    4'h3:    w_valE = valB ^ valA;
                    default: w_valE = '0;
                endcase
            end
            IC_JXX:             w_valE = '0;
            IC_CALL, IC_PUSHQ:  w_valE = valB - DATA_W'(8);
            IC_RET, IC_POPQ:    w_valE = valB + DATA_W'(8);
`ifdef Y86_EXEC_IADDQ_EN
            IC_IADDQ:           w_valE = valB + valC;
`endif
            default:            w_valE = '0;
        endcase
    end

    assign valE = w_valE;

    // Decide whether this instruction writes the flags and derive its overflow
    always_comb begin
        w_cc_en   = 1'b0;
        w_of_next = 1'b0;
        if (icode == IC_OPQ) begin
            case (ifun)
                4'h0: begin
                    w_cc_en   = 1'b1;
                    w_of_next = (valA[MSB] == valB[MSB]) && (w_valE[MSB] != valB[MSB]);
                end
                4'h1: begin
                    w_cc_en   = 1'b1;
                    w_of_next = (valA[MSB] != valB[MSB]) && (w_valE[MSB] != valB[MSB]);
                end
                4'h2, 4'h3: begin
                    w_cc_en   = 1'b1;
                    w_of_next = 1'b0;
                end
                default: begin
                    w_cc_en   = 1'b0;
                    w_of_next = 1'b0;
                end
            endcase
        end
`ifdef Y86_EXEC_IADDQ_EN
        else if (icode == IC_IADDQ) begin
            // iaddq uses the add overflow rule with the constant as the addend
            w_cc_en   = 1'b1;
            w_of_next = (valC[MSB] == valB[MSB]) && (w_valE[MSB] != valB[MSB]);
        end
`endif
    end

    // Condition-code register: reset has priority over a same-edge update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_en) begin
            r_zf <= (w_valE == '0);
            r_sf <= w_valE[MSB];
            r_of <= w_of_next;
        end
    end

    assign ZF = r_zf;
    assign SF = r_sf;
    assign OF = r_of;

    // Branch / conditional-move condition from the currently held flags
    always_comb begin
        w_lt  = r_sf ^ r_of;
        w_cnd = 1'b0;
        if ((icode == IC_RRMOVQ) || (icode == IC_JXX)) begin
            case (ifun)
                4'h0:    w_cnd = 1'b1;
                4'h1:    w_cnd = w_lt | r_zf;
                4'h2:    w_cnd = w_lt;
                4'h3:    w_cnd = r_zf;
                4'h4:    w_cnd = ~r_zf;
                4'h5:    w_cnd = ~w_lt;
                4'h6:    w_cnd = ~w_lt & ~r_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign cnd = w_cnd;

endmodule

// File: tb/tb_y86_execute.sv
// Testbench for y86_execute: directed vector table plus a model-checked
// random phase. Expected flags are queued when an instruction is driven
// and compared after the clock edge that should latch them.
module tb_y86_execute;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        ZF;
    logic        SF;
    logic        OF;
    logic        cnd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] exp_e;
        logic        exp_cnd;
        logic [2:0]  exp_flags;   // {ZF,SF,OF} after the edge
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];

    // model state for the random phase
    logic m_zf, m_sf, m_of;

    y86_execute #(.DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .icode (icode),
        .ifun  (ifun),
        .valA  (valA),
        .valB  (valB),
        .valC  (valC),
        .valE  (valE),
        .ZF    (ZF),
        .SF    (SF),
        .OF    (OF),
        .cnd   (cnd)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           input logic [63:0] e, input logic cd, input logic [2:0] fl);
        vec_t v;
        v.rst_n = r; v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c;
        v.exp_e = e; v.exp_cnd = cd; v.exp_flags = fl;
        vecs.push_back(v);
    endtask

    // drive one instruction, check combinational outputs, then flags after the edge
    task automatic apply(input int idx, input logic r, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] e, input logic cd, input logic [2:0] fl);
        logic [2:0] exp_fl;
        @(negedge clk);
        rst_n = r; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        exp_q.push_back(fl);
        #1;
        check("valE", idx, valE, e);
        check("cnd", idx, {63'd0, cnd}, {63'd0, cd});
        @(posedge clk);
        #1;
        exp_fl = exp_q.pop_front();
        check("flags", idx, {61'd0, ZF, SF, OF}, {61'd0, exp_fl});
    endtask

    function automatic logic [63:0] model_vale(input logic [3:0] ic, input logic [3:0] fn,
                                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: begin
                if (fn == 4'h0) return b + a;
                if (fn == 4'h1) return b - a;
                if (fn == 4'h2) return b & a;
                if (fn == 4'h3) return b ^ a;
                return 64'd0;
            end
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
`ifdef Y86_EXEC_IADDQ_EN
            4'hC: return b + c;
`endif
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic zf, input logic sf, input logic of_);
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            4'h0: return 1'b1;
            4'h1: return (sf ^ of_) | zf;
            4'h2: return sf ^ of_;
            4'h3: return zf;
            4'h4: return !zf;
            4'h5: return !(sf ^ of_);
            4'h6: return !(sf ^ of_) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // signed overflow from a 65-bit sign-extended result
    function automatic logic ovf_add(input logic [63:0] x, input logic [63:0] y);
        logic [64:0] s;
        s = {x[63], x} + {y[63], y};
        return s[64] ^ s[63];
    endfunction

    function automatic logic ovf_sub(input logic [63:0] b, input logic [63:0] a);
        logic [64:0] s;
        s = {b[63], b} - {a[63], a};
        return s[64] ^ s[63];
    endfunction

    initial begin
        logic [63:0] e, ra, rb, rc;
        logic [3:0]  ric, rfn;
        logic        cd, upd, nof;
        int          sel;

        rst_n = 1'b0; icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0;

        // reset block
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 0, {61'd0, ZF, SF, OF}, {61'd0, 3'b100});

        // directed vectors: {rst_n, icode, ifun, valA, valB, valC, valE, cnd, flags after}
        add_vec(1, 4'h2, 4'h3, 64'h11, 64'h0, 64'h0, 64'h11, 1, 3'b100);
        add_vec(1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b010);
        add_vec(1, 4'h2, 4'h2, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3'b010);
        add_vec(1, 4'h2, 4'h3, 64'h0, 64'h0, 64'h0, 64'h0, 0, 3'b010);
        add_vec(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b011);
        add_vec(1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 64'h0, 0, 3'b011);
        add_vec(1, 4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3'b011);
        add_vec(1, 4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 0, 3'b011);
        add_vec(1, 4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3'b011);
        add_vec(1, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 64'h0, 0, 3'b100);
        add_vec(1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h9, 64'h9, 0, 3'b100);
        add_vec(1, 4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3'b100);
        add_vec(1, 4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 64'h0, 0, 3'b100);
        add_vec(1, 4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 0, 3'b100);
        add_vec(1, 4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 64'h108, 0, 3'b100);
        add_vec(1, 4'h8, 4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 0, 3'b100);
        add_vec(1, 4'h9, 4'h0, 64'h0, 64'h100, 64'h0, 64'h108, 0, 3'b100);
        add_vec(1, 4'h4, 4'h0, 64'h0, 64'h100, 64'h20, 64'h120, 0, 3'b100);
        add_vec(1, 4'h5, 4'h0, 64'h0, 64'h100, 64'h20, 64'h120, 0, 3'b100);
        // 3 - 5 = -2 gives ZF=0 SF=1 so a spurious update by the invalid OPq shows up
        add_vec(1, 4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b010);
        add_vec(1, 4'h6, 4'h7, 64'h0, 64'h0, 64'h0, 64'h0, 0, 3'b010);
        add_vec(1, 4'h6, 4'h2, 64'hF0, 64'h0F, 64'h0, 64'h0, 0, 3'b100);
        add_vec(1, 4'h6, 4'h3, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 64'h8000_0000_0000_0001, 0, 3'b010);
        add_vec(1, 4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 3'b001);
        add_vec(1, 4'h2, 4'h0, 64'h77, 64'h0, 64'h0, 64'h77, 1, 3'b001);
        add_vec(1, 4'h2, 4'h8, 64'h0, 64'h0, 64'h0, 64'h0, 0, 3'b001);
        add_vec(1, 4'h1, 4'h0, 64'h5, 64'h5, 64'h5, 64'h0, 0, 3'b001);
`ifdef Y86_EXEC_IADDQ_EN
        add_vec(1, 4'hC, 4'h0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 3'b100);
`else
        add_vec(1, 4'hC, 4'h0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 3'b001);
`endif
        // set non-reset flags, then reset on the same edge as an OPq: reset wins
        add_vec(1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b010);
        add_vec(0, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b100);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i].rst_n, vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b,
                  vecs[i].c, vecs[i].exp_e, vecs[i].exp_cnd, vecs[i].exp_flags);
        end

        // random phase against the reference model, starting from reset flags
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      ric = 4'h6;
            else if (sel < 6) ric = 4'h7;
            else if (sel < 7) ric = 4'h2;
            else              ric = 4'($urandom_range(0, 15));
            rfn = (ric == 4'h6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            rc  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra[63] = ~ra[63];

            e   = model_vale(ric, rfn, ra, rb, rc);
            cd  = model_cnd(ric, rfn, m_zf, m_sf, m_of);
            upd = (ric == 4'h6) && (rfn <= 4'h3);
            nof = 1'b0;
            if (ric == 4'h6 && rfn == 4'h0) nof = ovf_add(ra, rb);
            if (ric == 4'h6 && rfn == 4'h1) nof = ovf_sub(rb, ra);
`ifdef Y86_EXEC_IADDQ_EN
            if (ric == 4'hC) begin
                upd = 1'b1;
                nof = ovf_add(rc, rb);
            end
`endif
            if (upd) begin
                m_zf = (e == 64'd0);
                m_sf = e[63];
                m_of = nof;
            end
            apply(1000 + i, 1'b1, ric, rfn, ra, rb, rc, e, cd, {m_zf, m_sf, m_of});
        end

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/y86_execute.md
Name: y86_execute

Overview:
Execute stage of the sequential Y86-64 processor, sitting between decode and memory. Computes the ALU result valE from the decoded operands and the instruction code. Holds the architectural condition-code register (ZF/SF/OF) and evaluates the branch/conditional-move condition cnd.

Parameters:
DATA_W, 64, operand/result width; fixed at 64, no other value supported.

Ports:
clk  input  1  system clock, rising edge active
rst_n  input  1  synchronous active-low reset
icode  input  4  instruction code from fetch/decode
ifun  input  4  function code from fetch/decode
valA  input  64  operand A (rA value)
valB  input  64  operand B (rB value / %rsp)
valC  input  64  instruction constant
valE  output  64  ALU result, combinational
ZF  output  1  zero flag, registered
SF  output  1  sign flag, registered
OF  output  1  signed-overflow flag, registered
cnd  output  1  condition result, combinational from current flags

Behaviour:
- Reset: on a rising clk edge with rst_n=0, set ZF=1, SF=0, OF=0. valE and cnd remain combinational and are not reset.
- valE is combinational and depends on icode:
  - 0 halt, 1 nop: 0.
  - 2 rrmovq/cmovXX: valA.
  - 3 irmovq: valC.
  - 4 rmmovq, 5 mrmovq: valB+valC.
  - 6 OPq:
    - ifun 0: valB+valA.
    - ifun 1: valB-valA.
    - ifun 2: valB&valA.
    - ifun 3: valB^valA.
    - other ifun: 0.
  - 7 jXX: 0.
  - 8 call, A pushq: valB-8.
  - 9 ret, B popq: valB+8.
  - Any other icode: 0.
- All arithmetic is modulo 2^64; no carry output.
- CC update:
  - At a rising clk edge with rst_n=1, icode=6 and ifun in 0..3, latch new flags from the OPq result.
  - ZF = (valE==0). SF = valE[63].
  - OF for add: valA[63]==valB[63] and valE[63]!=valB[63].
  - OF for sub: valA[63]!=valB[63] and valE[63]!=valB[63].
  - OF for and/xor: 0.
  - Otherwise flags hold. Invalid OPq ifun leaves flags unchanged.
- Flag latency: flags reflect an OPq one edge after it is presented; same-cycle instructions see the old flags.
- cnd is computed only when icode is 2 or 7; otherwise cnd=0. Per ifun:
  - 0: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~(SF^OF).
  - 6 g: ~(SF^OF)&~ZF.
  - 7..F: 0.
- Reset asserted at the same edge as an OPq: reset wins.

Optional Feature:
Macro Y86_EXEC_IADDQ_EN.
- Defined: icode C (iaddq) gives valE=valB+valC and updates CC at the edge using add-overflow rules, with valC in place of valA.
- Undefined: icode C is treated as unknown; valE=0, no CC update, cnd=0.

Test Plan:
- Reset: rst_n=0 for one edge -> ZF=1, SF=0, OF=0. Then icode=2, ifun=3 -> cnd=1.
- Add, no overflow: valA=valB=0xFFFF_FFFF_FFFF_FFFF, icode=6, ifun=0 -> valE=0xFFFF_FFFF_FFFF_FFFE. After the edge, ZF=0, SF=1, OF=0. Then icode=2, ifun=2 -> cnd=1; ifun=3 -> cnd=0.
- Add overflow: valA=valB=0x7FFF_FFFF_FFFF_FFFF, icode=6, ifun=0 -> valE=0xFFFF_FFFF_FFFF_FFFE. After the edge, OF=1, SF=1, ZF=0. Then icode=7, ifun=2 -> cnd=0; ifun=5 -> cnd=1.
- Sub to zero: valA=valB=5, icode=6, ifun=1 -> valE=0, ZF=1 after the edge. Follow with icode=3 (irmovq), valC=9 -> valE=9 with flags unchanged.
- Stack and memory address generation:
  - valB=0x100, icode=A -> valE=0xF8.
  - icode=B -> valE=0x108.
  - icode=4, valC=0x20 -> valE=0x120.
- Invalid OPq: icode=6, ifun=7 -> valE=0, flags unchanged over the edge. With Y86_EXEC_IADDQ_EN: icode=C, valB=1, valC=-1 -> valE=0, ZF=1 after the edge.
